// File: rtl/axis_stream_gen.sv
// AXI-Stream burst generator: emits a predictable sequence of beats (incrementing
// counter or Galois LFSR) with optional idle gaps between handshakes.
module axis_stream_gen #(
    parameter int FIFO_WIDTH = 32
) (
    input  logic                  m_axis_clk,
    input  logic                  m_axis_rst,
    input  logic                  start,
    input  logic [15:0]           burst_len,
    input  logic [7:0]            gap_cycles,
    input  logic                  mode,
    input  logic [31:0]           seed,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [FIFO_WIDTH-1:0] m_axis_tdata,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           beat_count
);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } state_e;

    state_e      state_q;
    logic [31:0] pattern_q;
    logic [31:0] patternAdv_d;
    logic [31:0] patternLoad_d;
    logic [15:0] len_q;
    logic [15:0] beatCount_q;
    logic [7:0]  gap_q;
    logic [7:0]  gapCnt_q;
    logic        mode_q;
    logic        tvalid_q;
    logic        busy_q;
    logic        done_q;
    logic        handshake;

    // LFSR taps for x^32+x^22+x^2+x+1 in right-shifting Galois form
    always_comb begin
        patternAdv_d = pattern_q + 32'd1;
        if (mode_q) begin
            patternAdv_d = (pattern_q >> 1) ^ (pattern_q[0] ? 32'h8020_0003 : 32'h0);
        end
    end

    // An all-zero LFSR would lock up, so a zero seed is promoted to 1
    always_comb begin
        patternLoad_d = seed;
        if (mode && (seed == 32'h0)) begin
            patternLoad_d = 32'h1;
        end
    end

    assign handshake = tvalid_q & m_axis_tready;

    always_ff @(posedge m_axis_clk) begin
        if (m_axis_rst) begin
            state_q     <= IDLE;
            pattern_q   <= 32'h0;
            len_q       <= 16'h0;
            beatCount_q <= 16'h0;
            gap_q       <= 8'h0;
            gapCnt_q    <= 8'h0;
            mode_q      <= 1'b0;
            tvalid_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        beatCount_q <= 16'h0;
                        if (burst_len != 16'h0) begin
                            len_q     <= burst_len;
                            gap_q     <= gap_cycles;
                            mode_q    <= mode;
                            pattern_q <= patternLoad_d;
                            state_q   <= SEND;
                            tvalid_q  <= 1'b1;
                            busy_q    <= 1'b1;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                SEND: begin
                    if (handshake) begin
                        beatCount_q <= beatCount_q + 16'd1;
                        pattern_q   <= patternAdv_d;
                        if ((beatCount_q + 16'd1) == len_q) begin
                            state_q  <= IDLE;
                            tvalid_q <= 1'b0;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                        end else if (gap_q != 8'h0) begin
                            state_q  <= GAP;
                            gapCnt_q <= gap_q;
                            tvalid_q <= 1'b0;
                        end
                    end
                end
                GAP: begin
                    if (gapCnt_q == 8'd1) begin
                        state_q  <= SEND;
                        tvalid_q <= 1'b1;
                    end else begin
                        gapCnt_q <= gapCnt_q - 8'd1;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    tvalid_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    // The pattern register is always 32 bits; adapt it to the bus width
    generate
        if (FIFO_WIDTH > 32) begin : gen_wide
            assign m_axis_tdata = {{(FIFO_WIDTH - 32){1'b0}}, pattern_q};
        end else if (FIFO_WIDTH == 32) begin : gen_exact
            assign m_axis_tdata = pattern_q;
        end else begin : gen_narrow
            assign m_axis_tdata = pattern_q[FIFO_WIDTH-1:0];
        end
    endgenerate

    assign m_axis_tvalid = tvalid_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign beat_count    = beatCount_q;

endmodule
